viterbi_feeder: RTL

Front-end driver for the three-HMM `viterbi` scorer. Accepts per-frame state log-likelihood triples from an upstream stream, stages one frame (STATE triples) locally, then runs the scorer's start/write/busy/dv handshake: load, arm, wait for scoring, capture `result`. Per-frame decisions are reported downstream, and a window tally over BAND frames gives a word-level vote. Sits between the feature/likelihood pipeline and `viterbi`.

---
 rtl/viterbi_pkg.sv | 26 ++
 rtl/viterbi_frame_buf.sv | 25 ++
 rtl/viterbi_feeder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the viterbi scorer front end.
// Build option: VITERBI_FEEDER_TIMEOUT_EN enables the ARM/RUN watchdog.
package viterbi_pkg;

  localparam int STATE_DEF   = 5;
  localparam int BAND_DEF    = 32;
  localparam int TIMEOUT_DEF = 1024;
  localparam int LLK_W       = 32;
  localparam int WD_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    ARM,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [LLK_W-1:0] d1;
    logic signed [LLK_W-1:0] d2;
    logic signed [LLK_W-1:0] d3;
  } triple_t;

endpackage

// File: rtl/viterbi_frame_buf.sv
// One-frame staging buffer: STATE likelihood triples,
// one synchronous write port, one asynchronous read port.
module viterbi_frame_buf
  import viterbi_pkg::*;
#(
  parameter int STATE = STATE_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(STATE)-1:0] waddr,
  input  triple_t                  wdata,
  input  logic [$clog2(STATE)-1:0] raddr,
  output triple_t                  rdata
);

  triple_t mem [STATE];

  // Contents survive reset; the fill counter makes stale data unreachable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_feeder.sv
// Stages one frame of triples and drives the viterbi scorer handshake.
// Build option: VITERBI_FEEDER_TIMEOUT_EN adds a sticky ARM/RUN watchdog.
module viterbi_feeder
  import viterbi_pkg::*;
#(
  parameter int STATE   = STATE_DEF,
  parameter int BAND    = BAND_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [LLK_W-1:0]    in_d1,
  input  logic signed [LLK_W-1:0]    in_d2,
  input  logic signed [LLK_W-1:0]    in_d3,
  output logic                       v_start,
  output logic                       v_write,
  output logic signed [LLK_W-1:0]    v_x1,
  output logic signed [LLK_W-1:0]    v_x2,
  output logic signed [LLK_W-1:0]    v_x3,
  input  logic                       v_busy,
  input  logic                       v_dv,
  input  logic                       v_result,
  output logic                       res_valid,
  output logic                       res_bit,
  output logic [$clog2(BAND)-1:0]    res_idx,
  output logic                       sum_valid,
  output logic [$clog2(BAND+1)-1:0]  sum_ones,
  output logic                       idle,
  output logic                       err
);

  localparam int CW = $clog2(STATE);
  localparam int IW = $clog2(BAND);
  localparam int SW = $clog2(BAND+1);
  localparam logic [CW-1:0] LAST_ST = CW'(STATE-1);
  localparam logic [IW-1:0] LAST_IX = IW'(BAND-1);

  state_t        state, nxt;
  logic [CW-1:0] fill_cnt, ld_cnt;
  logic [SW-1:0] acc;
  triple_t       wr, rd, x_q, x_out;
  logic          hit, tmo;

  assign wr  = '{d1: in_d1, d2: in_d2, d3: in_d3};
  assign hit = (state == RUN) && v_dv;

  viterbi_frame_buf #(.STATE(STATE)) u_buf (
    .clk   (clk),
    .we    (in_valid && in_ready),
    .waddr (fill_cnt),
    .wdata (wr),
    .raddr (ld_cnt),
    .rdata (rd)
  );

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    v_start  = 1'b0;
    v_write  = 1'b0;
    unique case (state)
      IDLE: nxt = FILL;
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && fill_cnt == LAST_ST) nxt = LOAD;
      end
      LOAD: begin
        v_start = 1'b1;
        v_write = 1'b1;
        if (ld_cnt == LAST_ST) nxt = ARM;
      end
      ARM: begin
        v_start = 1'b1;
        if (tmo) nxt = FILL;
        else if (v_busy) nxt = RUN;
      end
      RUN: begin
        v_start = 1'b1;
        if (v_dv) nxt = DONE;
        else if (tmo) nxt = FILL;
      end
      DONE: nxt = FILL;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      ld_cnt    <= '0;
      x_q       <= '0;
      res_valid <= 1'b0;
      res_bit   <= 1'b0;
      res_idx   <= '0;
      sum_valid <= 1'b0;
      sum_ones  <= '0;
      acc       <= '0;
    end else begin
      state     <= nxt;
      res_valid <= hit;
      sum_valid <= hit && (res_idx == LAST_IX);
      if (state == IDLE)
        fill_cnt <= '0;
      else if (in_valid && in_ready)
        fill_cnt <= (fill_cnt == LAST_ST) ? '0 : fill_cnt + 1'b1;
      if (state == LOAD) begin
        x_q    <= rd;
        ld_cnt <= (ld_cnt == LAST_ST) ? '0 : ld_cnt + 1'b1;
      end
      // Window tally lands with res_valid so sum_valid shares the DONE cycle.
      if (hit) begin
        res_bit <= v_result;
        if (res_idx == LAST_IX) begin
          sum_ones <= acc + SW'(v_result);
          acc      <= '0;
        end else begin
          acc <= acc + SW'(v_result);
        end
      end
      if (state == DONE)
        res_idx <= (res_idx == LAST_IX) ? '0 : res_idx + 1'b1;
    end
  end

  assign x_out = (state == LOAD) ? rd : x_q;
  assign v_x1  = x_out.d1;
  assign v_x2  = x_out.d2;
  assign v_x3  = x_out.d3;
  assign idle  = ((state == IDLE) || (state == FILL)) && (fill_cnt == '0);

`ifdef VITERBI_FEEDER_TIMEOUT_EN
  logic [WD_W-1:0] wd;
  logic            err_q;

  assign tmo = ((state == ARM) || (state == RUN)) && !hit &&
               (wd == WD_W'(TIMEOUT-1));
  assign err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state == ARM) || (state == RUN)) wd <= wd + 1'b1;
      else wd <= '0;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

endmodule
